down_counter_3_bit_load: RTL and testbench



---
 rtl/down_counter_3_bit_load.sv | 72 +++++++
 tb/tb_down_counter_3_bit_load.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/down_counter_3_bit_load.sv
// Loadable down counter with a one-cycle terminal-count pulse.
// Runs one-shot (stops at zero) or auto-reload (periodic divider).
module down_counter_3_bit_load #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_d;
    logic             mode_r, mode_d;
    logic             tc_d;

    function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
        return v - {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = Q;
        r_d     = r_q;
        mode_d  = mode_r;
        tc_d    = 1'b0;
        if (load) begin
            q_d     = D;
            r_d     = D;
            mode_d  = mode;
            state_d = (D != '0) ? COUNT : IDLE;
        end else if (state_q == COUNT && en) begin
            if (Q == '0) begin
                // Zero is only held in COUNT in auto-reload: wrap to the reload value.
                q_d = r_q;
            end else begin
                q_d = dec(Q);
                if (Q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    tc_d = 1'b1;
                    if (!mode_r) state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            Q       <= '0;
            r_q     <= '0;
            mode_r  <= 1'b0;
            tc      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            Q       <= q_d;
            r_q     <= r_d;
            mode_r  <= mode_d;
            tc      <= tc_d;
            busy    <= (state_d == COUNT);
        end
    end

endmodule

// File: tb/tb_down_counter_3_bit_load.sv
// Bench for down_counter_3_bit_load: directed test-plan steps followed by
// random traffic, all compared against a behavioural model of the counter.
module tb_down_counter_3_bit_load;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] D = '0;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] Q;
    logic         tc;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // behavioural reference state
    int m_q = 0;
    int m_r = 0;
    int m_mode = 0;
    int m_active = 0;
    int m_tc = 0;
    int tc_count = 0;

    down_counter_3_bit_load #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .D    (D),
        .en   (en),
        .mode (mode),
        .Q    (Q),
        .tc   (tc),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (reset) begin
            m_q = 0; m_r = 0; m_mode = 0; m_active = 0; m_tc = 0;
        end else if (load) begin
            m_q = int'(D); m_r = int'(D); m_mode = int'(mode);
            m_active = (D != 0); m_tc = 0;
        end else if (m_active != 0 && en) begin
            if (m_q == 0) begin
                m_q = m_r;
                m_tc = 0;
            end else begin
                m_q = m_q - 1;
                m_tc = (m_q == 0);
                if (m_tc != 0 && m_mode == 0) m_active = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic l, input int d, input logic e, input logic m);
        reset = r; load = l; D = W'(d); en = e; mode = m;
        @(posedge clk);
        model_step();
        #1;
        checks++;
        assert (Q === W'(m_q)) else begin
            errors++;
            $error("FAIL model_q observed %0d expected %0d", Q, m_q);
        end
        checks++;
        assert (tc === (m_tc != 0)) else begin
            errors++;
            $error("FAIL model_tc observed %0b expected %0b", tc, m_tc);
        end
        checks++;
        assert (busy === (m_active != 0)) else begin
            errors++;
            $error("FAIL model_busy observed %0b expected %0b", busy, m_active);
        end
        if (tc === 1'b1) tc_count++;
    endtask

    task automatic expect3(input string tag, input int q, input logic t, input logic b);
        checks++;
        assert (Q === W'(q) && tc === t && busy === b) else begin
            errors++;
            $error("FAIL %s observed q=%0d tc=%0b busy=%0b expected q=%0d tc=%0b busy=%0b",
                   tag, Q, tc, busy, q, t, b);
        end
    endtask

    initial begin
        // reset for two cycles
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        expect3("reset", 0, 0, 0);

        // one-shot D=5
        cyc(0, 1, 5, 1, 0); expect3("os_load", 5, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("os_4", 4, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("os_3", 3, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("os_2", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("os_1", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("os_0", 0, 1, 0);
        cyc(0, 0, 0, 1, 0); expect3("os_hold", 0, 0, 0);

        // auto-reload D=2
        cyc(0, 1, 2, 1, 1); expect3("ar_load", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("ar_1", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("ar_0", 0, 1, 1);
        cyc(0, 0, 0, 1, 0); expect3("ar_wrap", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("ar_1b", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("ar_0b", 0, 1, 1);

        // enable gating D=3 one-shot
        cyc(0, 1, 3, 0, 0); expect3("eg_load", 3, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("eg_2", 2, 0, 1);
        cyc(0, 0, 0, 0, 0); expect3("eg_hold1", 2, 0, 1);
        cyc(0, 0, 0, 0, 0); expect3("eg_hold2", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("eg_1", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("eg_0", 0, 1, 0);

        // load priority over terminal count
        cyc(0, 1, 2, 1, 0); expect3("lp_load", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); expect3("lp_1", 1, 0, 1);
        cyc(0, 1, 6, 1, 0); expect3("lp_reload", 6, 0, 1);
        cyc(0, 1, 0, 1, 0); expect3("lp_zero", 0, 0, 0);
        cyc(0, 0, 0, 1, 0); expect3("lp_zero_idle", 0, 0, 0);

        // reset mid-count in auto-reload
        cyc(0, 1, 7, 1, 1); expect3("rm_load", 7, 0, 1);
        cyc(0, 0, 0, 1, 1); expect3("rm_6", 6, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1); expect3("rm_4", 4, 0, 1);
        cyc(1, 0, 0, 1, 1); expect3("rm_reset", 0, 0, 0);
        cyc(0, 0, 0, 1, 1); expect3("rm_after", 0, 0, 0);

        // full range wrap, one tc per 8 enabled edges
        cyc(0, 1, 7, 1, 1); expect3("fr_load", 7, 0, 1);
        tc_count = 0;
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
        expect3("fr_end", 7, 0, 1);
        checks++;
        assert (tc_count == 2) else begin
            errors++;
            $error("FAIL fr_tc_count observed %0d expected 2", tc_count);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
